// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and word geometry.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] ALIGN_MASK = 32'(WORD_BYTES - 1);

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr & ALIGN_MASK) == 32'd0;
  endfunction

endpackage

// File: rtl/d_mem_array.sv
// Word RAM: synchronous write, registered read gated by a read enable.
module d_mem_array #(
  parameter int MemSize = 8
) (
  input  logic               clock,
  input  logic               we,
  input  logic [MemSize-1:0] waddr,
  input  logic [31:0]        wdata,
  input  logic               re,
  input  logic [MemSize-1:0] raddr,
  output logic [31:0]        rdata
);

  logic [31:0] mem [0:(2**MemSize)-1];
  logic [31:0] rdata_reg;

  // The read register only updates on an enabled read, so it holds its value between loads.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/d_mem_responder.sv
// Multi-cycle data-memory target: captures a load/store, inserts WAIT_CYCLES wait
// states, then pulses Ready (with Error on illegal accesses) while Stall holds the core.
module d_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int MemSize     = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Error,
  output logic        Stall
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t             state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [MemSize-1:0] addr_reg, addr_next;
  logic [31:0]        data_reg, data_next;
  logic               op_write_reg, op_write_next;
  logic               rd_seen_reg, rd_seen_next;

  logic               in_range;
  logic               req_ok;
  logic [MemSize-1:0] word_idx;
  logic               mem_we;
  logic               mem_re;
  logic [MemSize-1:0] mem_raddr;
  logic [31:0]        mem_rdata;

  assign word_idx = Address[MemSize+1:2];
  assign in_range = (Address >> (MemSize + 2)) == 32'd0;
  assign req_ok   = (MemRead ^ MemWrite) & is_aligned(Address) & in_range;

  // The array read is fired on the edge entering RESP so ReadData is valid with Ready.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    op_write_next = op_write_reg;
    rd_seen_next  = rd_seen_reg;
    mem_re        = 1'b0;
    mem_raddr     = addr_reg;
    case (state_reg)
      IDLE: begin
        if (MemRead | MemWrite) begin
          if (!req_ok) begin
            state_next = ERR;
          end else begin
            addr_next     = word_idx;
            data_next     = WriteData;
            op_write_next = MemWrite;
            cnt_next      = WAIT_LOAD;
            if (WAIT_LOAD == 4'd0) begin
              state_next   = RESP;
              mem_re       = MemRead;
              mem_raddr    = word_idx;
              rd_seen_next = rd_seen_reg | MemRead;
            end else begin
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next   = RESP;
          mem_re       = ~op_write_reg;
          rd_seen_next = rd_seen_reg | ~op_write_reg;
        end
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      data_reg     <= 32'd0;
      op_write_reg <= 1'b0;
      rd_seen_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      op_write_reg <= op_write_next;
      rd_seen_reg  <= rd_seen_next;
    end
  end

  // Store commits on the edge leaving RESP; an async reset during RESP drops it.
  assign mem_we = (state_reg == RESP) & op_write_reg;

  d_mem_array #(
    .MemSize(MemSize)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .waddr (addr_reg),
    .wdata (data_reg),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // The RAM output register has no reset; ReadData reads as zero until the first load.
  assign ReadData = rd_seen_reg ? mem_rdata : 32'd0;
  assign Ready    = (state_reg == RESP) | (state_reg == ERR);
  assign Error    = (state_reg == ERR);
  assign Stall    = (MemRead | MemWrite) & ~Ready;

endmodule

// File: tb/tb_d_mem_responder.sv
// Bench for d_mem_responder: two instances (WAIT_CYCLES=2 and 0) checked against an array model.
module tb_d_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic [1:0]  ready_w;
  logic [1:0]  error_w;
  logic [1:0]  stall_w;
  logic [31:0] rdata_w [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_model [2][256];
  logic [31:0] rd_model  [2];
  bit          recover;
  int          last_sel;

  always #5 clock = ~clock;

  d_mem_responder #(.MemSize(8), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemRead(mem_read[0]), .MemWrite(mem_write[0]), .ReadData(rdata_w[0]),
    .Ready(ready_w[0]), .Error(error_w[0]), .Stall(stall_w[0])
  );

  d_mem_responder #(.MemSize(8), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemRead(mem_read[1]), .MemWrite(mem_write[1]), .ReadData(rdata_w[1]),
    .Ready(ready_w[1]), .Error(error_w[1]), .Stall(stall_w[1])
  );

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      total++;
      if (stall_w !== 2'b00 || ready_w !== 2'b00) begin
        bad++;
        $display("FAIL idle_outputs: stall=%b ready=%b, required 00/00", stall_w, ready_w);
      end
    end
    recover = 0;
  endtask

  // One complete core access on instance sel; expectations come from the model.
  task automatic access(input int sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data, input bit scramble);
    int  w, rec, exp_lat, cyc;
    bit  legal, got;
    w       = (sel == 0) ? 2 : 0;
    legal   = (rd ^ wr) && (addr[1:0] == 2'b00) && (addr < 32'd1024);
    rec     = (recover && last_sel == sel) ? 1 : 0;
    exp_lat = rec + (legal ? w + 1 : 1);
    Address = addr; WriteData = data;
    mem_read[sel] = rd; mem_write[sel] = wr;
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (ready_w[sel] === 1'b1) begin
        got = 1;
      end else begin
        total++;
        if (stall_w[sel] !== 1'b1) begin
          bad++;
          $display("FAIL stall_busy: sel=%0d cyc=%0d stall=%b, required 1", sel, cyc, stall_w[sel]);
        end
        if (scramble && cyc >= rec + 1) begin
          Address = $urandom; WriteData = $urandom;
        end
      end
    end
    total++;
    if (cyc != exp_lat || !got) begin
      bad++;
      $display("FAIL latency: sel=%0d addr=%h got=%0d cycles (ready=%b), required %0d",
               sel, addr, cyc, got, exp_lat);
    end
    if (legal && wr) mem_model[sel][addr[9:2]] = data;
    if (legal && rd) rd_model[sel] = mem_model[sel][addr[9:2]];
    total++;
    if (error_w[sel] !== !legal) begin
      bad++;
      $display("FAIL error_flag: sel=%0d addr=%h error=%b, required %b", sel, addr, error_w[sel], !legal);
    end
    total++;
    if (stall_w[sel] !== 1'b0) begin
      bad++;
      $display("FAIL stall_ready: sel=%0d stall=%b, required 0", sel, stall_w[sel]);
    end
    total++;
    if (rdata_w[sel] !== rd_model[sel]) begin
      bad++;
      $display("FAIL read_data: sel=%0d addr=%h rdata=%h, required %h", sel, addr, rdata_w[sel], rd_model[sel]);
    end
    $display("txn sel=%0d rd=%0d wr=%0d addr=%h wdata=%h lat=%0d err=%b rdata=%h",
             sel, rd, wr, addr, data, cyc, error_w[sel], rdata_w[sel]);
    mem_read[sel] = 1'b0; mem_write[sel] = 1'b0;
    recover = 1; last_sel = sel;
  endtask

  task automatic test_reset();
    total++;
    if (ready_w !== 2'b00 || error_w !== 2'b00 || stall_w !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags: ready=%b error=%b stall=%b, required 00", ready_w, error_w, stall_w);
    end
    total++;
    if (rdata_w[0] !== 32'd0 || rdata_w[1] !== 32'd0) begin
      bad++;
      $display("FAIL reset_rdata: %h %h, required 0", rdata_w[0], rdata_w[1]);
    end
  endtask

  task automatic test_write_read_wait2();
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
    access(0, 1, 0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_wait0_back_to_back();
    access(1, 1, 0, 32'h0, 32'h0, 0);
    access(1, 0, 1, 32'h4, 32'h12345678, 0);
    access(1, 1, 0, 32'h4, 32'h0, 0);
  endtask

  task automatic test_errors();
    access(0, 1, 0, 32'h13, 32'h0, 0);
    access(0, 1, 0, 32'h10, 32'h0, 0);
    access(0, 0, 1, 32'h400, 32'hA5A5A5A5, 0);
    access(0, 1, 0, 32'h0, 32'h0, 0);
    access(0, 1, 1, 32'h20, 32'h55AA55AA, 0);
    access(0, 1, 0, 32'h20, 32'h0, 0);
  endtask

  task automatic test_reset_abort();
    idle(1);
    Address = 32'h8; WriteData = 32'hCAFEF00D; mem_write[0] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    total++;
    if (ready_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_pre_ready: ready=%b, required 0", ready_w[0]);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (ready_w !== 2'b00 || error_w !== 2'b00 || rdata_w[0] !== 32'd0) begin
      bad++;
      $display("FAIL abort_reset: ready=%b error=%b rdata=%h, required 00/00/0", ready_w, error_w, rdata_w[0]);
    end
    mem_write[0] = 1'b0;
    #1;
    total++;
    if (stall_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_stall: stall=%b, required 0", stall_w[0]);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    rd_model[0] = 32'd0; rd_model[1] = 32'd0;
    idle(2);
    access(0, 1, 0, 32'h8, 32'h0, 0);
  endtask

  task automatic test_random();
    int sel, kind;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 15)) * 32'd4;
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      case (kind)
        0:       access(sel, 1, 0, a | 32'($urandom_range(1, 3)), $urandom, 0);
        1:       access(sel, 0, 1, 32'h400 + a, $urandom, 0);
        2:       access(sel, 1, 1, a, $urandom, 0);
        3, 4, 5: access(sel, 0, 1, a, $urandom, $urandom_range(0, 1) == 1);
        default: access(sel, 1, 0, a, $urandom, $urandom_range(0, 1) == 1);
      endcase
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) mem_model[s][i] = 32'd0;
      rd_model[s] = 32'd0;
    end
    recover = 0; last_sel = 0;
    reset = 1'b1; Address = 32'd0; WriteData = 32'd0;
    mem_read = 2'b00; mem_write = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    idle(1);
    test_write_read_wait2();
    test_wait0_back_to_back();
    test_errors();
    test_reset_abort();
    test_random();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
